// File: rtl/hub75_frame_loader.sv
// Burst loader that streams 32-bit pixel words through a small FIFO into sequential frame-memory writes.
// Optional build macro HUB75_RB_SWAP_EN swaps the R/B bytes (bytes 0 and 2) at the output register.
module hub75_frame_loader #(
    parameter int ADDR_W     = 15,
    parameter int MEM_DEPTH  = 32768,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       word_count,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    input  logic              mem_hold,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_data,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  fifo_rd_ptr;
    logic [PTR_W-1:0]  fifo_wr_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_ptr_inc;
    logic [15:0]       in_left;
    logic [15:0]       out_left;

    logic              push;
    logic              pop;
    logic              load;
    logic              flush_fifo;
    logic              done_next;
    logic [31:0]       pop_word;
    logic [31:0]       out_word;

    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign pop_word   = fifo_mem[fifo_rd_ptr];
    assign busy       = (state != IDLE);

    // The frame memory is not necessarily a power of two deep, so wrap explicitly.
    assign wr_ptr_inc = (wr_ptr == ADDR_W'(MEM_DEPTH - 1)) ? '0 : wr_ptr + ADDR_W'(1);

`ifdef HUB75_RB_SWAP_EN
    assign out_word = {pop_word[31:24], pop_word[7:0], pop_word[15:8], pop_word[23:16]};
`else
    assign out_word = pop_word;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort has priority over both handshake and pop, so nothing is written after the abort cycle.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        load       = 1'b0;
        flush_fifo = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (word_count != 16'd0) begin
                        load       = 1'b1;
                        state_next = RUN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = FLUSH;
                end else begin
                    s_ready = !fifo_full && (in_left != 16'd0);
                    push    = s_valid && s_ready;
                    pop     = !fifo_empty && !mem_hold;
                    if (pop && (out_left == 16'd1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            FLUSH: begin
                flush_fifo = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_fifo) begin
            fifo_rd_ptr <= '0;
            fifo_wr_ptr <= '0;
            fifo_count  <= '0;
        end else begin
            if (push) begin
                fifo_wr_ptr <= fifo_wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Write strobe, address and data are registered one cycle after the pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_wr    <= 1'b0;
            mem_waddr <= '0;
            mem_data  <= '0;
            done      <= 1'b0;
            wr_ptr    <= '0;
            in_left   <= '0;
            out_left  <= '0;
        end else begin
            mem_wr <= pop;
            done   <= done_next;
            if (load) begin
                wr_ptr   <= base_addr;
                in_left  <= word_count;
                out_left <= word_count;
            end
            if (push) begin
                in_left <= in_left - 16'd1;
            end
            if (pop) begin
                mem_waddr <= wr_ptr;
                mem_data  <= out_word;
                wr_ptr    <= wr_ptr_inc;
                out_left  <= out_left - 16'd1;
            end
        end
    end

endmodule
